jt49_host: RTL and testbench
============================

# jt49_host

Host-side bus sequencer for the jt49 PSG register file. It accepts register write and read requests from a CPU or sound-driver core over a valid/ready interface and buffers them in a small FIFO. It plays each request onto the PSG's `addr`/`cs_n`/`wr_n`/`din` pins with fixed setup, strobe and gap timing, then returns read data from the PSG `dout` as a one-cycle response pulse. It sits between the system bus and the jt49 instance, in the same clock domain.

## Interface
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `STROBE_CYCLES`, 2: cycles `psg_cs_n`/`psg_wr_n` are held low per write; ≥1.
- `GAP_CYCLES`, 1: cycles with `psg_cs_n` high after every access; ≥1.
- `RD_LAT`, 2: cycles `psg_cs_n` is held low per read before capture; ≥1.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO not full; a request is accepted when `req_valid && req_ready`.
- `req_rd` in 1: 1 = read, 0 = write.
- `req_addr` in 4: PSG register index.
- `req_data` in 8: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse carrying read data.
- `rsp_data` out 8: captured read data; holds until the next read.
- `busy` out 1: FSM not IDLE or FIFO not empty.
- `psg_addr` out 4: to PSG `addr`.
- `psg_cs_n` out 1: to PSG `cs_n`.
- `psg_wr_n` out 1: to PSG `wr_n`.
- `psg_din` out 8: to PSG `din`.
- `psg_dout` in 8: from PSG `dout`. The PSG registers this output, so it is valid one cycle after `psg_addr` is stable.

## Operation
- FIFO: write on accept, pop when the FSM is IDLE and the FIFO is non-empty. Strict order. `req_ready = !full`, combinational from registered counters. No push is possible while full.
- FSM states: IDLE, SETUP, WRITE, READ, GAP.
  - IDLE, FIFO non-empty: pop, go to SETUP, load `psg_addr`. For a write, also load `psg_din`.
  - SETUP (1 cycle): `psg_cs_n=1`, `psg_wr_n=1`, address and data stable. Go to WRITE or READ.
  - WRITE (`STROBE_CYCLES`): `psg_cs_n=0`, `psg_wr_n=0`. Go to GAP.
  - READ (`RD_LAT`): `psg_cs_n=0`, `psg_wr_n=1`. On the last cycle's edge, capture `psg_dout` into `rsp_data` and set `rsp_valid` for exactly 1 cycle. Go to GAP.
  - GAP (`GAP_CYCLES`): `psg_cs_n=1`, `psg_wr_n=1`. Go to IDLE.
- GAP ≥1 guarantees the PSG sees a fresh rising edge of its internal write for every write. Consecutive writes to register 0xD each restart the envelope.
- `psg_addr`/`psg_din` hold their last values outside accesses.
- The block applies no read masking; `rsp_data` is exactly the PSG `dout`.
- All `psg_*`, `rsp_*` and `busy` outputs are registered.

## Timing
- Reset values: `psg_cs_n=1`, `psg_wr_n=1`, `psg_addr=0`, `psg_din=0`, `rsp_valid=0`, `rsp_data=0`, `busy=0`, `req_ready=1`, FIFO empty, state IDLE.
- Request accepted at edge N (FIFO empty, FSM IDLE):
  - the entry is visible from cycle N+1 and popped at edge N+2;
  - SETUP occupies cycle N+2;
  - strobe or read runs from cycle N+3.
- Write occupancy: 1 + `STROBE_CYCLES` + `GAP_CYCLES` + 1 (IDLE) cycles. Read occupancy is the same with `RD_LAT`.
- With defaults, back-to-back write strobes start every 5 cycles.
- `rsp_valid` is high in the first GAP cycle.
- Simultaneous push and pop are allowed when not full; the count is unchanged.
- Reset mid-access: at the reset edge, the strobe is released, the FIFO is flushed, and any pending response is dropped. No partial `rsp_valid` is produced.

## Structure
- Package `jt49_host_pkg`:
  - FSM state enum;
  - request struct `{rd, addr[3:0], data[7:0]}`;
  - register index constants: `REG_MIX=4'h7`, `REG_ENV_SHAPE=4'hD`, `REG_IOA=4'hE`, `REG_IOB=4'hF`.
- Sub-module `jt49_host_fifo`: synchronous FIFO parameterised by depth and width, providing full and empty flags.
- Top level contains the FSM, a shared down-counter for the SETUP, WRITE, READ and GAP states, and the output registers.

## Test plan
- Reset, then idle for 10 cycles → `psg_cs_n=psg_wr_n=1`, `req_ready=1`, `busy=0`, `rsp_valid` never high.
- Write addr 0x0, data 0x55, accepted at edge N (defaults) → `psg_addr=0`/`psg_din=0x55` from N+2; `psg_cs_n=psg_wr_n=0` on N+3 and N+4, both high on N+5; PSG model reg0 = 0x55.
- Writes to 0xD of 0x0E, then 0x0A, back to back → two strobes separated by ≥1 cycle of `psg_cs_n=1`; PSG envelope restart pulses twice; reg 0xD = 0x0A.
- Write 0xFF to 0x1, then read 0x1 → one `rsp_valid` pulse with `rsp_data=0x0F` (PSG mask); `rsp_data` holds afterwards.
- Push 5 requests in 5 consecutive cycles (FIFO_DEPTH=4) → `req_ready` drops after the 4th entry is held, reasserts after the first pop; PSG sees all 5 in order.
- Assert `rst_n=0` for 1 cycle during a WRITE strobe with 2 requests queued → next cycle `psg_cs_n=psg_wr_n=1`, `busy=0`, no further PSG accesses, no `rsp_valid`.

Source files
------------

// File: rtl/jt49_host_pkg.sv
// Shared types and constants for the jt49 host-side bus sequencer.
package jt49_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWrite,
    StRead,
    StGap
  } state_e;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } req_t;

  localparam int unsigned ReqW = $bits(req_t);

  localparam logic [3:0] REG_MIX       = 4'h7;
  localparam logic [3:0] REG_ENV_SHAPE = 4'hD;
  localparam logic [3:0] REG_IOA       = 4'hE;
  localparam logic [3:0] REG_IOB       = 4'hF;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jt49_host_if.sv
// Host request/response channel between a CPU or sound driver and jt49_host.
interface jt49_host_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rd;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  modport master (
    output req_valid, req_rd, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_rd, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jt49_host_fifo.sv
// Synchronous request FIFO; a pushed entry becomes poppable one cycle after the push.
module jt49_host_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] used
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q, vis_ptr_q;
  logic             do_push, do_pop;

  assign used    = wr_ptr_q - rd_ptr_q;
  assign full    = (used == FullLevel);
  // Read side compares against a delayed copy of the write pointer.
  assign empty   = (rd_ptr_q == vis_ptr_q);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      vis_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      vis_ptr_q <= wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jt49_host.sv
// Plays queued host register requests onto the jt49 PSG pins with fixed
// setup/strobe/gap timing and returns read data as a one-cycle pulse.
module jt49_host
  import jt49_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1,
  parameter int unsigned RD_LAT        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  jt49_host_if.slave  bus,
  output logic [3:0]  psg_addr,
  output logic        psg_cs_n,
  output logic        psg_wr_n,
  output logic [7:0]  psg_din,
  input  logic [7:0]  psg_dout
);

  localparam int unsigned MaxCyc = max3(STROBE_CYCLES, GAP_CYCLES, RD_LAT);
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t StrobeLd = cnt_t'(STROBE_CYCLES - 1);
  localparam cnt_t GapLd    = cnt_t'(GAP_CYCLES - 1);
  localparam cnt_t RdLd     = cnt_t'(RD_LAT - 1);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  req_t   wreq, head;
  logic   fifo_full, fifo_empty, push, pop, capture, busy_d;
  logic [$clog2(FIFO_DEPTH):0] fifo_used;

  logic       rd_q, cs_n_q, wr_n_q, rsp_valid_q, busy_q;
  logic [3:0] addr_q;
  logic [7:0] din_q, rsp_data_q;

  assign wreq = '{rd: bus.req_rd, addr: bus.req_addr, data: bus.req_data};
  assign push = bus.req_valid && !fifo_full;
  assign pop  = (state_q == StIdle) && !fifo_empty;

  jt49_host_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ReqW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wreq),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .used  (fifo_used)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        state_d = rd_q ? StRead : StWrite;
        cnt_d   = rd_q ? RdLd : StrobeLd;
      end
      StWrite, StRead: begin
        if (cnt_q == '0) begin
          capture = (state_q == StRead);
          state_d = StGap;
          cnt_d   = GapLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // No pop can coincide with a next state of IDLE, so the queue is empty after
  // this edge only if nothing is stored and nothing is being pushed.
  assign busy_d = (state_d != StIdle) || push || (fifo_used != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= !(state_d == StWrite || state_d == StRead);
      wr_n_q      <= (state_d != StWrite);
      rsp_valid_q <= capture;
      busy_q      <= busy_d;
      if (pop) begin
        rd_q   <= head.rd;
        addr_q <= head.addr;
        if (!head.rd) din_q <= head.data;
      end
      if (capture) rsp_data_q <= psg_dout;
    end
  end

  assign psg_addr      = addr_q;
  assign psg_din       = din_q;
  assign psg_cs_n      = cs_n_q;
  assign psg_wr_n      = wr_n_q;
  assign bus.req_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_jt49_host.sv
// Bench for jt49_host: PSG pin model, in-order reference model, table vectors,
// timing sequences and randomized traffic.
module tb_jt49_host;
  import jt49_host_pkg::*;

  localparam int unsigned STROBE = 2;
  localparam int unsigned GAP    = 1;
  localparam int unsigned RDL    = 2;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] psg_addr;
  logic       psg_cs_n, psg_wr_n;
  logic [7:0] psg_din;
  logic [7:0] psg_dout = 8'h00;

  int errors = 0;
  int checks = 0;

  jt49_host_if bus ();

  jt49_host #(
    .FIFO_DEPTH    (4),
    .STROBE_CYCLES (STROBE),
    .GAP_CYCLES    (GAP),
    .RD_LAT        (RDL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .psg_addr (psg_addr),
    .psg_cs_n (psg_cs_n),
    .psg_wr_n (psg_wr_n),
    .psg_din  (psg_din),
    .psg_dout (psg_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] rd_mask(input logic [3:0] a);
    case (a)
      4'h1, 4'h3, 4'h5, 4'hD: rd_mask = 8'h0F;
      4'h6, 4'h8, 4'h9, 4'hA: rd_mask = 8'h1F;
      default:                rd_mask = 8'hFF;
    endcase
  endfunction

  // PSG register file with a registered, masked read port.
  logic [7:0] psg_regs [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (!psg_cs_n && !psg_wr_n) psg_regs[psg_addr] <= psg_din;
    psg_dout <= psg_regs[psg_addr] & rd_mask(psg_addr);
  end

  // Reference model: requests take effect in acceptance order.
  logic [7:0] model_regs [16] = '{default: 8'h00};
  acc_t       exp_acc[$];
  logic [7:0] exp_rsp[$];

  task automatic model_accept(input logic rd, input logic [3:0] a, input logic [7:0] d);
    exp_acc.push_back('{rd: rd, addr: a, data: d});
    if (rd) exp_rsp.push_back(model_regs[a] & rd_mask(a));
    else    model_regs[a] = d;
  endtask

  // Pin monitor: each access start is matched against the expected order.
  logic prev_act = 1'b0, cur_wr = 1'b0, have_prev = 1'b0, prev_rsp = 1'b0;
  int   len = 0, gap_len = 0, env_cnt = 0, acc_cnt = 0, rsp_cnt = 0;
  always @(negedge clk) begin
    acc_t e;
    logic [7:0] r;
    if (!rst_n) begin
      prev_act = 1'b0; have_prev = 1'b0; len = 0; prev_rsp = 1'b0;
    end else begin
      if (!psg_cs_n && !prev_act) begin
        acc_cnt++;
        checks++;
        if (exp_acc.size() == 0) begin
          errors++;
          $display("FAIL access_order: unexpected access addr=%h wr_n=%b", psg_addr, psg_wr_n);
        end else begin
          e = exp_acc.pop_front();
          if (e.rd != psg_wr_n || e.addr != psg_addr || (!e.rd && e.data != psg_din)) begin
            errors++;
            $display("FAIL access_order: got rd=%b addr=%h din=%h want rd=%b addr=%h din=%h",
                     psg_wr_n, psg_addr, psg_din, e.rd, e.addr, e.data);
          end
        end
        if (have_prev) begin
          checks++;
          if (gap_len < int'(GAP) + 2) begin
            errors++;
            $display("FAIL access_gap: got %0d idle cycles want >= %0d", gap_len, GAP + 2);
          end
        end
        if (!psg_wr_n && psg_addr == REG_ENV_SHAPE) env_cnt++;
        cur_wr = !psg_wr_n;
        len = 1;
      end else if (!psg_cs_n) begin
        len++;
      end else if (prev_act) begin
        checks++;
        if (len != int'(cur_wr ? STROBE : RDL)) begin
          errors++;
          $display("FAIL strobe_len: got %0d want %0d", len, cur_wr ? STROBE : RDL);
        end
        have_prev = 1'b1;
        gap_len = 1;
      end else begin
        gap_len++;
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        checks++;
        if (exp_rsp.size() == 0 || prev_rsp) begin
          errors++;
          $display("FAIL rsp_pulse: unexpected rsp_valid data=%h", bus.rsp_data);
        end else begin
          r = exp_rsp.pop_front();
          if (bus.rsp_data != r) begin
            errors++;
            $display("FAIL rsp_data: got %h want %h", bus.rsp_data, r);
          end
        end
      end
      prev_act = !psg_cs_n;
      prev_rsp = bus.rsp_valid;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic rd, input logic [3:0] a, input logic [7:0] d);
    bit done = 1'b0;
    bus.req_valid = 1'b1; bus.req_rd = rd; bus.req_addr = a; bus.req_data = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        model_accept(rd, a, d);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (!done) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.busy && exp_acc.size() == 0 && exp_rsp.size() == 0;
    end
    check("idle_reached", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  vec_t       tbl [12];
  acc_t       batch [6];
  logic [8:0] rdy_vec;
  int         idx, a0;
  bit         seen;

  initial begin
    bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    tbl[0]  = '{rd: 1'b0, addr: 4'h1, data: 8'hFF, exp: 8'h00};
    tbl[1]  = '{rd: 1'b1, addr: 4'h1, data: 8'h00, exp: 8'h0F};
    tbl[2]  = '{rd: 1'b0, addr: 4'h6, data: 8'hFF, exp: 8'h00};
    tbl[3]  = '{rd: 1'b1, addr: 4'h6, data: 8'h00, exp: 8'h1F};
    tbl[4]  = '{rd: 1'b0, addr: 4'h7, data: 8'hA5, exp: 8'h00};
    tbl[5]  = '{rd: 1'b1, addr: 4'h7, data: 8'h00, exp: 8'hA5};
    tbl[6]  = '{rd: 1'b0, addr: 4'hD, data: 8'h3C, exp: 8'h00};
    tbl[7]  = '{rd: 1'b1, addr: 4'hD, data: 8'h00, exp: 8'h0C};
    tbl[8]  = '{rd: 1'b0, addr: 4'hE, data: 8'h81, exp: 8'h00};
    tbl[9]  = '{rd: 1'b1, addr: 4'hE, data: 8'h00, exp: 8'h81};
    tbl[10] = '{rd: 1'b0, addr: 4'h8, data: 8'hF7, exp: 8'h00};
    tbl[11] = '{rd: 1'b1, addr: 4'h8, data: 8'h00, exp: 8'h17};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle", {psg_cs_n, psg_wr_n, bus.req_ready, bus.busy, bus.rsp_valid},
            5'b11100);
    end
    check("reset_addr_din", {psg_addr, psg_din}, 12'h000);
    @(posedge clk); #1;

    // Single write timing, accepted at edge N.
    issue(1'b0, 4'h0, 8'h55);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("wr_timing_cs_wr_n%0d", i), {psg_cs_n, psg_wr_n},
            (i == 3 || i == 4) ? 2'b00 : 2'b11);
      if (i >= 2) check($sformatf("wr_timing_pins%0d", i), {psg_addr, psg_din}, 12'h055);
    end
    wait_idle();
    check("psg_reg0", psg_regs[0], 8'h55);

    // Table vectors.
    foreach (tbl[k]) begin
      issue(tbl[k].rd, tbl[k].addr, tbl[k].data);
      if (tbl[k].rd) begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (bus.rsp_valid) begin
            seen = 1'b1;
            check($sformatf("tbl_rsp%0d", k), bus.rsp_data, tbl[k].exp);
          end
        end
        if (!seen) check($sformatf("tbl_rsp_seen%0d", k), 32'd0, 32'd1);
      end
      wait_idle();
      if (!tbl[k].rd) check($sformatf("tbl_psg_reg%0d", k), psg_regs[tbl[k].addr], tbl[k].data);
    end
    repeat (8) @(negedge clk);
    check("rsp_hold", {bus.rsp_valid, bus.rsp_data}, 9'h017);
    @(posedge clk); #1;

    // Back-to-back envelope-shape writes.
    a0 = env_cnt;
    issue(1'b0, REG_ENV_SHAPE, 8'h0E);
    issue(1'b0, REG_ENV_SHAPE, 8'h0A);
    wait_idle();
    check("env_restarts", env_cnt - a0, 2);
    check("env_reg", psg_regs[13], 8'h0A);

    // Burst into the FIFO from idle: ready pattern per cycle until all accepted.
    for (int i = 0; i < 6; i++) batch[i] = '{rd: 1'b0, addr: 4'(i + 2), data: 8'(8'h30 + i)};
    rdy_vec = '0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      bus.req_valid = 1'b1; bus.req_rd = 1'b0;
      bus.req_addr = batch[idx].addr; bus.req_data = batch[idx].data;
      @(negedge clk);
      if (c < 9) rdy_vec[c] = bus.req_ready;
      if (bus.req_ready) begin
        model_accept(1'b0, batch[idx].addr, batch[idx].data);
        idx++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    check("burst_accepted", idx, 6);
    check("burst_ready_pattern", rdy_vec, 9'b1_0001_1111);
    wait_idle();

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      issue($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 8'($urandom));
    end
    wait_idle();
    check("random_rsp_drained", exp_rsp.size(), 0);

    // Reset during a write strobe with two requests queued.
    issue(1'b0, 4'h2, 8'h11);
    issue(1'b0, 4'h3, 8'h22);
    issue(1'b0, 4'h4, 8'h33);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !psg_cs_n && !psg_wr_n;
    end
    check("strobe_before_reset", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_acc.delete();
    exp_rsp.delete();
    a0 = acc_cnt;
    idx = rsp_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_mid_pins", {psg_cs_n, psg_wr_n, bus.busy, bus.rsp_valid, bus.req_ready},
          5'b11001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_mid_quiet", {psg_cs_n, bus.busy, bus.rsp_valid}, 3'b100);
    end
    check("reset_mid_no_access", acc_cnt - a0, 0);
    check("reset_mid_no_rsp", rsp_cnt - idx, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
